// File: rtl/mavg_ctrl.sv
// Round-robin sample scheduler and start/stop/flush sequencer for the shared moving-average lane.
// Optional slot pacing via a grant-period down-counter when MAVG_CTRL_PERIOD_EN is defined.
module mavg_ctrl #(
    parameter int WINDOW_SIZE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       stop,
    input  logic       flush,
    input  logic [7:0] period,
    input  logic [2:0] ch_valid,
    input  logic [5:0] ch_data,
    output logic [2:0] ch_ready,
    output logic       dp_load,
    output logic [1:0] dp_ch,
    output logic [1:0] dp_data,
    output logic       dp_clr,
    output logic [2:0] win_full,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [3:0] WIN = 4'(WINDOW_SIZE);

    state_t          state, state_nx;
    logic [1:0]      last;
    logic [2:0][3:0] fill, fill_nx;
    logic            tick, gnt_en, hs;
    logic [1:0]      gnt_ch;
    logic [1:0]      ord0, ord1, ord2;

`ifdef MAVG_CTRL_PERIOD_EN
    logic [7:0] per_cnt;
    assign tick = (per_cnt == 8'd0);
`else
    logic unused_period;
    assign unused_period = ^period;
    assign tick = 1'b1;
`endif

    always_comb begin
        state_nx = state;
        if (ena) begin
            if (flush) state_nx = FLUSH;
            else begin
                case (state)
                    FLUSH:   state_nx = IDLE;
                    RUN:     if (stop)  state_nx = IDLE;
                    IDLE:    if (start) state_nx = RUN;
                    default: state_nx = IDLE;
                endcase
            end
        end
    end

    // Search order starts one past the last granted channel.
    always_comb begin
        case (last)
            2'd0:    begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
            2'd1:    begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
            default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
        endcase
    end

    assign gnt_en = ena && (state == RUN) && !flush && !stop && tick;

    always_comb begin
        ch_ready = 3'b000;
        gnt_ch   = 2'd0;
        if (gnt_en) begin
            if (ch_valid[ord0])      begin ch_ready[ord0] = 1'b1; gnt_ch = ord0; end
            else if (ch_valid[ord1]) begin ch_ready[ord1] = 1'b1; gnt_ch = ord1; end
            else if (ch_valid[ord2]) begin ch_ready[ord2] = 1'b1; gnt_ch = ord2; end
        end
    end

    assign hs = |(ch_ready & ch_valid);

    always_comb begin
        fill_nx = fill;
        for (int i = 0; i < 3; i++)
            if (ch_ready[i] && ch_valid[i] && fill[i] != WIN)
                fill_nx[i] = fill[i] + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 2'd2;
            fill     <= '0;
            dp_load  <= 1'b0;
            dp_ch    <= 2'd0;
            dp_data  <= 2'd0;
            dp_clr   <= 1'b0;
            win_full <= 3'b000;
            busy     <= 1'b0;
        end else if (ena) begin
            state   <= state_nx;
            busy    <= (state_nx != IDLE);
            dp_load <= hs;
            dp_clr  <= flush;
            if (hs) begin
                dp_ch   <= gnt_ch;
                dp_data <= ch_data[{gnt_ch, 1'b0} +: 2];
            end
            if (flush) begin
                last     <= 2'd2;
                fill     <= '0;
                win_full <= 3'b000;
            end else begin
                if (hs) last <= gnt_ch;
                fill <= fill_nx;
                for (int i = 0; i < 3; i++)
                    win_full[i] <= (fill_nx[i] == WIN);
            end
        end else begin
            dp_load <= 1'b0;
            dp_clr  <= 1'b0;
        end
    end

`ifdef MAVG_CTRL_PERIOD_EN
    // Counter sits at zero outside RUN so the first grant after start is immediate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            per_cnt <= 8'd0;
        else if (ena) begin
            if (state_nx != RUN || flush) per_cnt <= 8'd0;
            else if (hs)                  per_cnt <= period;
            else if (per_cnt != 8'd0)     per_cnt <= per_cnt - 8'd1;
        end
    end
`endif

endmodule
